// File: rtl/axis_wb_writer.sv
// rtl/axis_wb_writer.sv - AXI-Stream to Wishbone single-word write engine
// Optional early termination on ss_tlast: define AXIS_WB_TLAST_EN.
module axis_wb_writer #(
  parameter int FIFO_DEPTH = 2,
  parameter int LEN_W      = 10
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count,
  input  logic             ss_tvalid,
  output logic             ss_tready,
  input  logic [31:0]      ss_tdata,
`ifdef AXIS_WB_TLAST_EN
  input  logic             ss_tlast,
`endif
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  output logic             wbs_we_o,
  output logic [3:0]       wbs_sel_o,
  output logic [31:0]      wbs_adr_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             wbs_ack_i
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_fifo_cnt;
  logic [LEN_W-1:0] r_len, r_accepted, r_count;
  logic [31:0]      r_next_adr, r_adr, r_dat;
  logic             r_stb, r_cyc;

  logic w_full, w_empty, w_push, w_pop, w_ack, w_final;

  assign w_full  = (r_fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_fifo_cnt == '0);
  assign w_push  = ss_tvalid && ss_tready;
  assign w_ack   = r_stb && wbs_ack_i;
  assign w_final = w_ack && ((r_count + LEN_W'(1)) == r_len);
  // The output register doubles as the head of the queue: refill it when empty or being acked.
  assign w_pop   = (r_state == S_RUN) && !w_empty && (!r_stb || w_ack) && !w_final;

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    ss_tready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (len == '0) ? S_FLUSH : S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        ss_tready = !w_full && (r_accepted < r_len);
        if (w_final) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= ss_tdata;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_accepted <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_next_adr <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_stb      <= 1'b0;
      r_cyc      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_len      <= len;
        r_accepted <= '0;
        r_count    <= '0;
        r_next_adr <= base_addr & 32'hFFFF_FFFC;
      end
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_accepted <= r_accepted + LEN_W'(1);
`ifdef AXIS_WB_TLAST_EN
        // Shrinking the target length both closes ss_tready and moves the final-ack point.
        if (ss_tlast) r_len <= r_accepted + LEN_W'(1);
`endif
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW+1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW+1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_ack) r_count <= r_count + LEN_W'(1);
      if (w_pop) begin
        r_stb      <= 1'b1;
        r_cyc      <= 1'b1;
        r_adr      <= r_next_adr;
        r_dat      <= r_mem[r_rd_ptr];
        r_next_adr <= r_next_adr + 32'd4;
      end else if (w_ack) begin
        r_stb <= 1'b0;
        if (w_final) r_cyc <= 1'b0;
      end
    end
  end

  assign count     = r_count;
  assign wbs_cyc_o = r_cyc;
  assign wbs_stb_o = r_stb;
  assign wbs_we_o  = r_cyc;
  assign wbs_sel_o = r_stb ? 4'hF : 4'h0;
  assign wbs_adr_o = r_adr;
  assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_axis_wb_writer.sv
// tb/tb_axis_wb_writer.sv - scoreboard bench for axis_wb_writer
// Random stream and Wishbone slave; expected writes come from base + 4*k and the beat data.
module tb_axis_wb_writer;
  localparam int FIFO_DEPTH = 2;
  localparam int LEN_W      = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done;
  logic [LEN_W-1:0] count;
  logic             ss_tvalid = 1'b0;
  logic             ss_tready;
  logic [31:0]      ss_tdata = '0;
`ifdef AXIS_WB_TLAST_EN
  logic             ss_tlast = 1'b0;
`endif
  logic             wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [3:0]       wbs_sel_o;
  logic [31:0]      wbs_adr_o, wbs_dat_o;
  logic             wbs_ack_i = 1'b0;

  axis_wb_writer #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .count(count),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata),
`ifdef AXIS_WB_TLAST_EN
    .ss_tlast(ss_tlast),
`endif
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_ack_i(wbs_ack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  logic [63:0] exp_q[$];

  bit          mon_en = 1'b0;
  int          done_cnt, ack_cnt, done_cycle, start_cycle;
  bit          cyc_seen, busy_seen;
  bit          prev_stb, prev_ack, prev_cyc;
  logic [31:0] prev_adr, prev_dat;

  int          ack_delay = 0;
  bit          ack_rand  = 1'b0;
  int          wait_cnt  = 0;

  logic [31:0] cur_base;
  int          cur_words, beats, tlast_at, valid_pct, max_out;
  bit          spur_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  // Wishbone slave: fixed wait states per word, or random ack independent of stb.
  initial forever begin
    @(posedge clk);
    #1;
    if (ack_rand) begin
      wbs_ack_i = 1'($urandom_range(0, 1));
    end else if (wbs_stb_o && !rst) begin
      if (wait_cnt >= ack_delay) begin
        wbs_ack_i = 1'b1;
        wait_cnt  = 0;
      end else begin
        wbs_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      wbs_ack_i = 1'b0;
      wait_cnt  = 0;
    end
  end

  // Monitor: pops the scoreboard on every acknowledged strobe.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (wbs_stb_o) begin
        chk("strobe_attrs", {wbs_cyc_o, wbs_we_o, wbs_sel_o}, {1'b1, 1'b1, 4'hF});
        if (prev_stb && !prev_ack) begin
          chk("adr_stable", wbs_adr_o, prev_adr);
          chk("dat_stable", wbs_dat_o, prev_dat);
        end
      end
      if (prev_cyc && ack_cnt < cur_words) chk("cyc_hold", wbs_cyc_o, 1'b1);
      if (wbs_stb_o && wbs_ack_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {wbs_adr_o, wbs_dat_o}, 64'hx);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("write_adr", wbs_adr_o, e[63:32]);
          chk("write_dat", wbs_dat_o, e[31:0]);
        end
        ack_cnt++;
      end
      if (wbs_cyc_o) cyc_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        if (done_cnt == 0) done_cycle = cyc_no;
        done_cnt++;
      end
      prev_stb = wbs_stb_o;
      prev_ack = wbs_ack_i;
      prev_cyc = wbs_cyc_o;
      prev_adr = wbs_adr_o;
      prev_dat = wbs_dat_o;
    end else begin
      prev_stb = 1'b0;
      prev_cyc = 1'b0;
    end
  end

  task automatic cycle_step();
    int outstanding;
    @(posedge clk);
    #1;
    start = 1'b0;
    outstanding = beats - ack_cnt;
    if (outstanding > max_out) max_out = outstanding;
    if (outstanding > FIFO_DEPTH + 1) chk("buffer_bound", outstanding, FIFO_DEPTH + 1);
    if (spur_en && busy && $urandom_range(0, 7) == 0) begin
      start = 1'b1;
      len   = LEN_W'($urandom_range(0, 20));
    end
    ss_tvalid = ($urandom_range(0, 99) < valid_pct);
    ss_tdata  = $urandom;
`ifdef AXIS_WB_TLAST_EN
    ss_tlast  = (tlast_at != 0) && (beats + 1 == tlast_at);
`endif
    @(negedge clk);
    if (beats >= cur_words && ss_tready) chk("tready_after_last", ss_tready, 1'b0);
    if (ss_tvalid && ss_tready) begin
      exp_q.push_back({cur_base + 32'(4 * beats), ss_tdata});
      beats++;
    end
  endtask

  task automatic launch(input logic [31:0] base, input int l, input int vpct, input int ad,
                        input bit arand, input int tl);
    done_cnt  = 0;
    ack_cnt   = 0;
    cyc_seen  = 1'b0;
    busy_seen = 1'b0;
    beats     = 0;
    max_out   = 0;
    tlast_at  = 0;
    cur_base  = base & 32'hFFFF_FFFC;
    cur_words = l;
`ifdef AXIS_WB_TLAST_EN
    tlast_at  = tl;
    if (tl >= 1 && tl < l) cur_words = tl;
`endif
    valid_pct = vpct;
    ack_delay = ad;
    ack_rand  = arand;
    @(posedge clk);
    #1;
    start       = 1'b1;
    base_addr   = base;
    len         = LEN_W'(l);
    start_cycle = cyc_no;
  endtask

  task automatic run_xfer(input logic [31:0] base, input int l, input int vpct, input int ad,
                          input bit arand, input int tl);
    launch(base, l, vpct, ad, arand, tl);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) cycle_step();
    valid_pct = 0;
    repeat (3) cycle_step();
    chk("done_once", done_cnt, 1);
    chk("acks", ack_cnt, cur_words);
    chk("beats", beats, cur_words);
    chk("count", count, LEN_W'(cur_words));
    chk("busy_idle", busy, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);
    if (l == 0) begin
      chk("zero_len_no_cyc", cyc_seen, 1'b0);
      chk("zero_len_no_busy", busy_seen, 1'b0);
      chk("zero_len_done_latency_ok", (done_cycle - start_cycle >= 1) && (done_cycle - start_cycle <= 2), 1'b1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o}, 7'h0);
    chk("rst_adr_dat", {wbs_adr_o, wbs_dat_o}, 64'h0);
    chk("rst_status", {busy, done, ss_tready, count}, '0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    run_xfer(32'h3800_0000, 4, 100, 0, 1'b0, 0);
    run_xfer(32'h1000_0000, 3, 100, 3, 1'b0, 0);
    run_xfer(32'h2000_0000, 6, 100, 3, 1'b0, 0);
    chk("fifo_fills", max_out, FIFO_DEPTH + 1);
    run_xfer(32'h4000_0000, 0, 100, 0, 1'b0, 0);
    run_xfer(32'hFFFF_FFFC, 2, 100, 0, 1'b0, 0);
    run_xfer(32'h1234_5677, 3, 60, 1, 1'b0, 0);

    launch(32'h5000_0000, 5, 100, 1, 1'b0, 0);
    for (int i = 0; i < 200 && ack_cnt < 2; i++) cycle_step();
    chk("pre_reset_acks", ack_cnt, 2);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ss_tvalid = 1'b0;
    @(negedge clk);
    chk("mid_rst_cyc_stb", {wbs_cyc_o, wbs_stb_o}, 2'b00);
    chk("mid_rst_busy_count", {busy, count}, '0);
    chk("mid_rst_tready", ss_tready, 1'b0);
    exp_q.delete();
    mon_en = 1'b1;
    run_xfer(32'h6000_0000, 1, 100, 0, 1'b0, 0);

`ifdef AXIS_WB_TLAST_EN
    run_xfer(32'h7000_0000, 8, 100, 0, 1'b0, 3);
`endif

    spur_en = 1'b1;
    for (int t = 0; t < 14; t++) begin
      int l, tl;
      l  = $urandom_range(1, 12);
      tl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, l) : 0;
      run_xfer($urandom, l, $urandom_range(30, 100), $urandom_range(0, 2), 1'($urandom_range(0, 1)), tl);
    end
    spur_en  = 1'b0;
    ack_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
